sequence_game_ctrl: RTL and testbench

//  Generalised colour-sequence memory game controller. It grows a random sequence one entry per round.
//  It plays the sequence back with separate on/off phases and checks the player's replay.

---
 rtl/sequence_game_pkg.sv | 22 ++
 rtl/sequence_game_ctrl_tick_counter.sv | 24 ++
 rtl/sequence_game_ctrl.sv | 155 +++++++++++++++
 tb/tb_sequence_game_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sequence_game_pkg.sv
// sequence_game_pkg: state encoding and width helpers shared by the sequence game blocks
package sequence_game_pkg;

    typedef enum logic [2:0] {IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN_S, LOSE_S, END} state_t;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int color_w(input int ncolors);
        return clog2_min1(ncolors);
    endfunction

    function automatic int len_w(input int max_len);
        return (max_len < 1) ? 1 : $clog2(max_len + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/sequence_game_ctrl_tick_counter.sv
// tick_counter: counts time-base pulses up to a target; done flags the pulse that reaches it
module tick_counter
    import sequence_game_pkg::*;
#(
    parameter int TW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          pulse,
    input  logic [TW-1:0] target,
    output logic          done
);

    logic [TW-1:0] count;

    // pulse counter, restarted whenever the owner changes phase
    always_ff @(posedge CLK) begin
        count <= (RST || clr) ? '0 : pulse ? count + TW'(1) : count;
    end

    assign done = pulse && (count + TW'(1) == target);

endmodule

// File: rtl/sequence_game_ctrl.sv
// sequence_game_ctrl: grows a random colour sequence, plays it back and checks the player's replay
module sequence_game_ctrl
    import sequence_game_pkg::*;
#(
    parameter  int NCOLORS        = 4,
    parameter  int MAX_LEN        = 32,
    parameter  int ON_PULSES      = 2,
    parameter  int OFF_PULSES     = 1,
    parameter  int TIMEOUT_PULSES = 8,
    localparam int CW             = color_w(NCOLORS),
    localparam int LW             = len_w(MAX_LEN)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [CW-1:0] IN,
    input  logic          IN_VALID,
    input  logic [CW-1:0] RAND,
    input  logic          TIMER_PULSE,
    output logic [CW-1:0] OUT,
    output logic          OUT_EN,
    output logic [LW-1:0] SCORE,
    output logic [LW-1:0] HIGH_SCORE,
    output logic          NEW_HS,
    output logic          WIN,
    output logic          LOSE,
    output logic          BUSY
);

    localparam int AW = clog2_min1(MAX_LEN);
    localparam int TW = len_w(max3(ON_PULSES, OFF_PULSES, TIMEOUT_PULSES));

    state_t        state_q, state_n;
    logic [LW-1:0] cnt_q, cnt_n, i_q, i_n, score_n, hs_n;
    logic [CW-1:0] stack_q [MAX_LEN];
    logic [CW-1:0] rand_fold, cur, out_n;
    logic          out_en_n, new_hs_n, win_n, lose_n, push, last;
    logic          tick_pulse, tick_clr, tick_done;
    logic [TW-1:0] tick_target;

    assign rand_fold   = (int'(RAND) >= NCOLORS) ? CW'(int'(RAND) - NCOLORS) : RAND;
    assign cur         = stack_q[i_q[AW-1:0]];
    assign last        = i_q == cnt_q - LW'(1);
    assign tick_pulse  = TIMER_PULSE && (state_q == SHOW_ON || state_q == SHOW_OFF ||
                                         (state_q == INPUT && TIMEOUT_PULSES != 0));
    assign tick_target = (state_q == SHOW_ON)  ? TW'(ON_PULSES) :
                         (state_q == SHOW_OFF) ? TW'(OFF_PULSES) : TW'(TIMEOUT_PULSES);
    assign tick_clr    = (state_n != state_q) || (state_q == INPUT && IN_VALID);

    tick_counter #(.TW(TW)) u_tick (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (tick_clr),
        .pulse  (tick_pulse),
        .target (tick_target),
        .done   (tick_done)
    );

    // next-state logic; outputs are precomputed here so they can be registered
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        i_n      = i_q;
        score_n  = SCORE;
        hs_n     = HIGH_SCORE;
        new_hs_n = 1'b0;
        win_n    = WIN;
        lose_n   = LOSE;
        push     = 1'b0;
        case (state_q)
            IDLE: if (START) begin
                cnt_n   = '0;
                i_n     = '0;
                score_n = '0;
                win_n   = 1'b0;
                lose_n  = 1'b0;
                state_n = ADD;
            end
            ADD: if (cnt_q == LW'(MAX_LEN)) begin
                state_n = WIN_S;
            end else begin
                push    = 1'b1;
                cnt_n   = cnt_q + LW'(1);
                i_n     = '0;
                state_n = SHOW_ON;
            end
            SHOW_ON: if (tick_done) state_n = SHOW_OFF;
            SHOW_OFF: if (tick_done) begin
                i_n     = last ? '0 : i_q + LW'(1);
                state_n = last ? INPUT : SHOW_ON;
            end
            INPUT: if (IN_VALID) begin
                if (IN != cur) begin
                    state_n = LOSE_S;
                end else if (last) begin
                    score_n = cnt_q;
                    state_n = ADD;
                end else begin
                    i_n = i_q + LW'(1);
                end
            end else if (tick_done && TIMEOUT_PULSES != 0) begin
                state_n = LOSE_S;
            end
            WIN_S: begin
                win_n   = 1'b1;
                score_n = LW'(MAX_LEN);
                state_n = END;
            end
            LOSE_S: begin
                lose_n  = 1'b1;
                state_n = END;
            end
            END: begin
                hs_n     = (SCORE > HIGH_SCORE) ? SCORE : HIGH_SCORE;
                new_hs_n = SCORE > HIGH_SCORE;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
        out_en_n = state_n == SHOW_ON;
        out_n    = !out_en_n ? '0 : (state_q == ADD && cnt_q == '0) ? rand_fold : stack_q[i_n[AW-1:0]];
    end

    // state, counters, sequence stack and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            i_q        <= '0;
            OUT        <= '0;
            OUT_EN     <= 1'b0;
            SCORE      <= '0;
            HIGH_SCORE <= '0;
            NEW_HS     <= 1'b0;
            WIN        <= 1'b0;
            LOSE       <= 1'b0;
            BUSY       <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) stack_q[k] <= '0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            i_q        <= i_n;
            OUT        <= out_n;
            OUT_EN     <= out_en_n;
            SCORE      <= score_n;
            HIGH_SCORE <= hs_n;
            NEW_HS     <= new_hs_n;
            WIN        <= win_n;
            LOSE       <= lose_n;
            BUSY       <= state_n != IDLE;
            if (push) stack_q[cnt_q[AW-1:0]] <= rand_fold;
        end
    end

endmodule

// File: tb/tb_sequence_game_ctrl.sv
// tb_sequence_game_ctrl: table of whole games plus hand sequences, displayed colours scoreboarded
module tb_sequence_game_ctrl;

    typedef struct {
        logic [7:0] rands;
        int         fail_round;
        int         fail_at;
        bit         tmo;
        bit         late;
        int         score;
        bit         win;
        bit         lose;
        int         hs;
        int         nhs;
    } game_t;

    typedef struct {
        logic [1:0] colour;
        bit         first;
    } show_t;

    logic       CLK = 1'b0, RST = 1'b1, START = 1'b0, IN_VALID = 1'b0, TIMER_PULSE = 1'b0;
    logic [1:0] IN = '0, RAND = '0, OUT;
    logic [2:0] SCORE, HIGH_SCORE;
    logic       OUT_EN, NEW_HS, WIN, LOSE, BUSY;

    int         checks = 0, errors = 0, nhs_cnt = 0, on_ticks = 0, off_ticks = 0;
    logic       prev_en = 1'b0;
    show_t      exp_q[$];
    show_t      e, s;
    logic [1:0] seq[$];
    game_t      tbl[6];
    int         nhs0;
    bit         lost;

    sequence_game_ctrl #(.NCOLORS(3), .MAX_LEN(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .IN(IN), .IN_VALID(IN_VALID), .RAND(RAND),
        .TIMER_PULSE(TIMER_PULSE), .OUT(OUT), .OUT_EN(OUT_EN), .SCORE(SCORE),
        .HIGH_SCORE(HIGH_SCORE), .NEW_HS(NEW_HS), .WIN(WIN), .LOSE(LOSE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse();
        TIMER_PULSE = 1'b1;
        step();
        TIMER_PULSE = 1'b0;
        step();
        step();
    endtask

    function automatic logic [1:0] fold(input logic [1:0] r);
        return (r >= 2'd3) ? r - 2'd3 : r;
    endfunction

    // display monitor: pops expected colours, measures on/off phase lengths, counts NEW_HS cycles
    always @(negedge CLK) begin
        if (RST) begin
            prev_en   = 1'b0;
            on_ticks  = 0;
            off_ticks = 0;
        end else begin
            if (OUT_EN && !prev_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_show: colour %0d displayed with nothing expected", OUT);
                end else begin
                    e = exp_q.pop_front();
                    chk("show_colour", OUT, e.colour);
                    if (!e.first) chk("off_ticks", off_ticks, 1);
                end
                on_ticks = 0;
            end
            if (!OUT_EN && prev_en) begin
                chk("on_ticks", on_ticks, 2);
                off_ticks = 0;
            end
            if (TIMER_PULSE) begin
                if (OUT_EN) on_ticks++;
                else off_ticks++;
            end
            if (NEW_HS) nhs_cnt++;
            prev_en = OUT_EN;
        end
    end

    initial begin
        //          rands (r1 in [1:0])  frnd fat tmo late score win lose hs nhs
        tbl[0] = '{8'b00_00_01_10, 3, 1, 1'b0, 1'b0, 2, 1'b0, 1'b1, 2, 1};
        tbl[1] = '{8'b00_10_11_01, 0, 0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 4, 1};
        tbl[2] = '{8'b00_00_01_11, 2, 0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 4, 0};
        tbl[3] = '{8'b00_00_00_10, 1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 4, 0};
        tbl[4] = '{8'b00_00_10_01, 2, 1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 4, 0};
        tbl[5] = '{8'b10_10_01_00, 0, 0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 4, 0};

        step();
        step();
        chk("rst_out", OUT, 0);
        chk("rst_out_en", OUT_EN, 0);
        chk("rst_score", SCORE, 0);
        chk("rst_high_score", HIGH_SCORE, 0);
        chk("rst_new_hs", NEW_HS, 0);
        chk("rst_win", WIN, 0);
        chk("rst_lose", LOSE, 0);
        chk("rst_busy", BUSY, 0);
        RST = 1'b0;
        step();

        for (int g = 0; g < 6; g++) begin
            nhs0 = nhs_cnt;
            lost = 1'b0;
            seq.delete();
            RAND  = tbl[g].rands[1:0];
            START = 1'b1;
            step();
            START = 1'b0;
            seq.push_back(fold(RAND));
            step();
            for (int r = 1; r <= 4 && !lost; r++) begin
                exp_q.delete();
                foreach (seq[k]) begin
                    s.colour = seq[k];
                    s.first  = (k == 0);
                    exp_q.push_back(s);
                end
                repeat (3 * r) pulse();
                chk("shown_all", exp_q.size(), 0);
                if (r < 4) RAND = tbl[g].rands[2*r +: 2];
                if (r == tbl[g].fail_round && tbl[g].tmo) begin
                    repeat (8) pulse();
                    lost = 1'b1;
                end
                for (int k = 0; k < r && !lost; k++) begin
                    if (r == 1 && k == 0 && tbl[g].late) begin
                        repeat (7) pulse();
                        TIMER_PULSE = 1'b1;
                    end
                    lost     = (r == tbl[g].fail_round) && (k == tbl[g].fail_at);
                    IN       = lost ? (seq[k] ^ 2'd1) : seq[k];
                    IN_VALID = 1'b1;
                    step();
                    IN_VALID    = 1'b0;
                    TIMER_PULSE = 1'b0;
                    step();
                end
                if (!lost) begin
                    chk("round_score", SCORE, r);
                    if (r < 4) seq.push_back(fold(RAND));
                end
            end
            for (int w = 0; w < 20 && BUSY; w++) step();
            chk("idle_after_game", BUSY, 0);
            step();
            step();
            chk("game_score", SCORE, tbl[g].score);
            chk("game_win", WIN, tbl[g].win);
            chk("game_lose", LOSE, tbl[g].lose);
            chk("game_high_score", HIGH_SCORE, tbl[g].hs);
            chk("game_new_hs_cycles", nhs_cnt - nhs0, tbl[g].nhs);
        end

        RAND  = 2'd1;
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        exp_q.delete();
        s.colour = 2'd1;
        s.first  = 1'b1;
        exp_q.push_back(s);
        step();
        START = 1'b1;
        step();
        START = 1'b0;
        chk("start_ignored_out_en", OUT_EN, 1);
        chk("start_ignored_busy", BUSY, 1);
        chk("start_ignored_out", OUT, 1);
        chk("shown_before_reset", exp_q.size(), 0);
        RST = 1'b1;
        step();
        chk("midrst_out", OUT, 0);
        chk("midrst_out_en", OUT_EN, 0);
        chk("midrst_score", SCORE, 0);
        chk("midrst_high_score", HIGH_SCORE, 0);
        chk("midrst_new_hs", NEW_HS, 0);
        chk("midrst_win", WIN, 0);
        chk("midrst_lose", LOSE, 0);
        chk("midrst_busy", BUSY, 0);
        step();
        RST = 1'b0;
        step();
        step();
        chk("post_rst_idle", BUSY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
